interp_bilinear_stream: RTL and testbench

Parametrised, streaming bilinear interpolator for the rectification datapath. It takes four neighbour pixels (lu/ru/ld/rd) and fractional offsets dx/dy, and produces one interpolated pixel per beat over CH packed channels. Weights are exact (2^F − d, d), so the four weights always sum to 2^(2F). Output uses selectable round-to-nearest or truncation. Full valid/ready handshake with per-stage valids and bubble collapse. Out-of-bounds samples are replaced by a fill value. Sits between the coordinate/fetch unit and the output pixel FIFO.

---
 rtl/interp_pkg.sv | 21 ++
 rtl/interp_lane.sv | 63 ++++++
 rtl/interp_bilinear_stream.sv | 138 +++++++++++++
 tb/tb_interp_bilinear_stream.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared widths and rounding constants for the bilinear interpolator.
// Imported by interp_lane and interp_bilinear_stream.
package interp_pkg;

   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_NEAREST = 1;

   // dx/dy weights span 1..2^F, so one extra bit
   function automatic int weight_w(input int frac_w);
      return frac_w + 1;
   endfunction

   function automatic int wprod_w(input int frac_w);
      return 2 * frac_w + 2;
   endfunction

   function automatic int acc_w(input int pix_w, input int frac_w);
      return pix_w + 2 * frac_w + 2;
   endfunction

endpackage

// File: rtl/interp_lane.sv
// One channel of the bilinear datapath: S3 corner products, S4 sum/round/fill.
// Ports: clk, rst, en3/en4 stage loads, lu/ru/ld/rd pixels, w_* weights, oob, pix out.
module interp_lane
   import interp_pkg::*;
#(
   parameter int               FRAC_W = 6,
   parameter int               PIX_W  = 8,
   parameter int               ROUND  = ROUND_NEAREST,
   parameter logic [PIX_W-1:0] FILL   = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en3,
   input  logic                         en4,
   input  logic [PIX_W-1:0]             lu,
   input  logic [PIX_W-1:0]             ru,
   input  logic [PIX_W-1:0]             ld,
   input  logic [PIX_W-1:0]             rd,
   input  logic [wprod_w(FRAC_W)-1:0]   w_lu,
   input  logic [wprod_w(FRAC_W)-1:0]   w_ru,
   input  logic [wprod_w(FRAC_W)-1:0]   w_ld,
   input  logic [wprod_w(FRAC_W)-1:0]   w_rd,
   input  logic                         oob,
   output logic [PIX_W-1:0]             pix
);

   localparam int AW = acc_w(PIX_W, FRAC_W);
   localparam logic [AW-1:0] RND =
      (ROUND == ROUND_NEAREST) ? (AW'(1) << (2 * FRAC_W - 1)) : '0;

   logic [AW-1:0]    p_lu, p_ru, p_ld, p_rd;
   logic [AW-1:0]    acc;
   logic [PIX_W-1:0] res;
   logic             unused_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         p_lu <= '0;
         p_ru <= '0;
         p_ld <= '0;
         p_rd <= '0;
      end else if (en3) begin
         p_lu <= AW'(lu) * AW'(w_lu);
         p_ru <= AW'(ru) * AW'(w_ru);
         p_ld <= AW'(ld) * AW'(w_ld);
         p_rd <= AW'(rd) * AW'(w_rd);
      end
   end

   // weights sum to 2^(2F): the sum never exceeds PIX_W bits after the shift
   always_comb begin
      acc = p_lu + p_ru + p_ld + p_rd + RND;
      res = oob ? FILL : acc[2*FRAC_W +: PIX_W];
   end

   assign unused_acc = ^{acc[AW-1:2*FRAC_W+PIX_W], acc[2*FRAC_W-1:0]};

   always_ff @(posedge clk) begin
      if (rst)      pix <= '0;
      else if (en4) pix <= res;
   end

endmodule

// File: rtl/interp_bilinear_stream.sv
// Streaming 4-stage bilinear interpolator with valid/ready and bubble collapse.
// Ports: s_* input beat (dx, dy, 4 neighbours, oob, last), m_* output beat, busy.
module interp_bilinear_stream
   import interp_pkg::*;
#(
   parameter int               FRAC_W = 6,
   parameter int               PIX_W  = 8,
   parameter int               CH     = 1,
   parameter int               ROUND  = ROUND_NEAREST,
   parameter logic [PIX_W-1:0] FILL   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [FRAC_W-1:0]     s_dx,
   input  logic [FRAC_W-1:0]     s_dy,
   input  logic [CH*PIX_W-1:0]   s_lu,
   input  logic [CH*PIX_W-1:0]   s_ru,
   input  logic [CH*PIX_W-1:0]   s_ld,
   input  logic [CH*PIX_W-1:0]   s_rd,
   input  logic                  s_oob,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CH*PIX_W-1:0]   m_pix,
   output logic                  m_last,
   output logic                  busy
);

   localparam int WW = weight_w(FRAC_W);
   localparam int PW = wprod_w(FRAC_W);
   localparam int DW = CH * PIX_W;
   localparam logic [WW-1:0] ONE = WW'(1) << FRAC_W;

   logic v1, v2, v3, v4;
   logic ld1, ld2, ld3, ld4;
   logic en1, en2, en3, en4;

   logic [FRAC_W-1:0] dx1, dy1;
   logic [WW-1:0]     wx1, wy1;
   logic [DW-1:0]     lu1, ru1, ld1_p, rd1;
   logic              oob1, last1;

   logic [PW-1:0]     w_lu2, w_ru2, w_ld2, w_rd2;
   logic [DW-1:0]     lu2, ru2, ld2_p, rd2;
   logic              oob2, last2;

   logic              oob3, last3;

   // a stage loads when empty or when its successor is loading
   always_comb begin
      ld4 = !v4 | m_ready;
      ld3 = !v3 | ld4;
      ld2 = !v2 | ld3;
      ld1 = !v1 | ld2;
      en1 = ld1 & s_valid;
      en2 = ld2 & v1;
      en3 = ld3 & v2;
      en4 = ld4 & v3;
   end

   assign s_ready = ld1;
   assign m_valid = v4;
   assign busy    = v1 | v2 | v3 | v4;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         v3     <= 1'b0;
         v4     <= 1'b0;
         m_last <= 1'b0;
      end else begin
         if (ld1) v1 <= s_valid;
         if (ld2) v2 <= v1;
         if (ld3) v3 <= v2;
         if (ld4) v4 <= v3;
         if (en4) m_last <= last3;
      end
   end

   always_ff @(posedge clk) begin
      if (en1) begin
         dx1   <= s_dx;
         dy1   <= s_dy;
         wx1   <= ONE - {1'b0, s_dx};
         wy1   <= ONE - {1'b0, s_dy};
         lu1   <= s_lu;
         ru1   <= s_ru;
         ld1_p <= s_ld;
         rd1   <= s_rd;
         oob1  <= s_oob;
         last1 <= s_last;
      end
      if (en2) begin
         w_lu2 <= PW'(wx1) * PW'(wy1);
         w_ru2 <= PW'(dx1) * PW'(wy1);
         w_ld2 <= PW'(wx1) * PW'(dy1);
         w_rd2 <= PW'(dx1) * PW'(dy1);
         lu2   <= lu1;
         ru2   <= ru1;
         ld2_p <= ld1_p;
         rd2   <= rd1;
         oob2  <= oob1;
         last2 <= last1;
      end
      if (en3) begin
         oob3  <= oob2;
         last3 <= last2;
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_lane
      interp_lane #(
         .FRAC_W (FRAC_W),
         .PIX_W  (PIX_W),
         .ROUND  (ROUND),
         .FILL   (FILL)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .en3  (en3),
         .en4  (en4),
         .lu   (lu2[g*PIX_W +: PIX_W]),
         .ru   (ru2[g*PIX_W +: PIX_W]),
         .ld   (ld2_p[g*PIX_W +: PIX_W]),
         .rd   (rd2[g*PIX_W +: PIX_W]),
         .w_lu (w_lu2),
         .w_ru (w_ru2),
         .w_ld (w_ld2),
         .w_rd (w_rd2),
         .oob  (oob3),
         .pix  (m_pix[g*PIX_W +: PIX_W])
      );
   end

endmodule

// File: tb/tb_interp_bilinear_stream.sv
// Scoreboard bench: two DUTs (round / truncate, CH=3, FILL=0x10) on one stream.
// Expected pixels come from a direct weighted-sum model of the four corners.
module tb_interp_bilinear_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic [5:0]  s_dx = '0, s_dy = '0;
   logic [23:0] s_lu = '0, s_ru = '0, s_ld = '0, s_rd = '0;
   logic        s_oob = 1'b0, s_last = 1'b0;
   logic        m_ready = 1'b1;
   logic        s_ready_a, s_ready_b;
   logic        m_valid_a, m_valid_b;
   logic [23:0] m_pix_a, m_pix_b;
   logic        m_last_a, m_last_b;
   logic        busy_a, busy_b;

   always #5 clk = ~clk;

   interp_bilinear_stream #(
      .FRAC_W(6), .PIX_W(8), .CH(3), .ROUND(1), .FILL(8'h10)
   ) dut_a (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a),
      .s_dx(s_dx), .s_dy(s_dy), .s_lu(s_lu), .s_ru(s_ru),
      .s_ld(s_ld), .s_rd(s_rd), .s_oob(s_oob), .s_last(s_last),
      .m_valid(m_valid_a), .m_ready(m_ready), .m_pix(m_pix_a),
      .m_last(m_last_a), .busy(busy_a)
   );

   interp_bilinear_stream #(
      .FRAC_W(6), .PIX_W(8), .CH(3), .ROUND(0), .FILL(8'h10)
   ) dut_b (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b),
      .s_dx(s_dx), .s_dy(s_dy), .s_lu(s_lu), .s_ru(s_ru),
      .s_ld(s_ld), .s_rd(s_rd), .s_oob(s_oob), .s_last(s_last),
      .m_valid(m_valid_b), .m_ready(m_ready), .m_pix(m_pix_b),
      .m_last(m_last_b), .busy(busy_b)
   );

   typedef struct {
      logic [23:0] r;
      logic [23:0] t;
      logic        last;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_acc   = 0;
   int   n_out   = 0;
   bit   rand_rdy = 1'b0;
   bit   drv_done;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // value = sum(corner * area weight) / 4096 for each 8-bit channel
   function automatic logic [23:0] model(input int dx, input int dy,
      input logic [23:0] lu, input logic [23:0] ru,
      input logic [23:0] ld, input logic [23:0] rd,
      input bit oob, input bit rnd);
      logic [23:0] res;
      int t;
      res = '0;
      for (int c = 0; c < 3; c++) begin
         t = int'(lu[c*8 +: 8]) * (64 - dx) * (64 - dy)
           + int'(ru[c*8 +: 8]) * dx * (64 - dy)
           + int'(ld[c*8 +: 8]) * (64 - dx) * dy
           + int'(rd[c*8 +: 8]) * dx * dy;
         if (rnd) t = t + 2048;
         res[c*8 +: 8] = oob ? 8'h10 : 8'(t / 4096);
      end
      return res;
   endfunction

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [5:0] dx, input logic [5:0] dy,
      input logic [23:0] lu, input logic [23:0] ru,
      input logic [23:0] ld, input logic [23:0] rd,
      input bit oob, input bit last,
      input logic [23:0] er, input logic [23:0] et);
      exp_t e;
      bit   ok;
      s_dx = dx; s_dy = dy;
      s_lu = lu; s_ru = ru; s_ld = ld; s_rd = rd;
      s_oob = oob; s_last = last;
      s_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         ok = s_ready_a;
         if (ok) begin
            e.r = er; e.t = et; e.last = last;
            q.push_back(e);
            n_acc++;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: got no s_ready expected accept");
      end
      s_valid = 1'b0;
   endtask

   task automatic rsend(input bit oob_ok);
      logic [5:0]  dx, dy;
      logic [23:0] lu, ru, ld, rd;
      bit          oob, last;
      dx = 6'($urandom); dy = 6'($urandom);
      lu = 24'($urandom); ru = 24'($urandom);
      ld = 24'($urandom); rd = 24'($urandom);
      oob  = oob_ok && ($urandom_range(0, 9) == 0);
      last = 1'($urandom);
      send(dx, dy, lu, ru, ld, rd, oob, last,
           model(int'(dx), int'(dy), lu, ru, ld, rd, oob, 1'b1),
           model(int'(dx), int'(dy), lu, ru, ld, rd, oob, 1'b0));
   endtask

   task automatic drain();
      int i;
      i = 0;
      while ((q.size() != 0 || busy_a) && i < 3000) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk("drain_empty", 32'(q.size()), 0);
   endtask

   // scoreboard monitor: compares on every output handshake
   logic [23:0] held_pix;
   bit          held_v = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 1'b0;
         end else begin
            if (held_v && m_valid_a)
               chk("stall_hold", m_pix_a, held_pix);
            if (m_valid_a || m_valid_b)
               chk("valid_ab", m_valid_b, m_valid_a);
            if (m_valid_a && m_ready) begin
               if (q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_out: got %0h expected none", m_pix_a);
               end else begin
                  e = q.pop_front();
                  chk("pix_round", m_pix_a, e.r);
                  chk("pix_trunc", m_pix_b, e.t);
                  chk("last", m_last_a, e.last);
                  n_out++;
               end
            end
            held_v   = m_valid_a && !m_ready;
            held_pix = m_pix_a;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) m_ready = 1'($urandom);
      end
   end

   initial begin
      int lat;
      int base;
      int outs;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_m_valid", m_valid_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_m_pix", m_pix_a, 0);
      chk("rst_m_last", m_last_a, 0);
      chk("rst_s_ready", s_ready_a, 1);
      @(posedge clk);
      #1;

      // dx=dy=0 returns lu; first-beat latency
      send(6'd0, 6'd0, 24'h252525, 24'hC8C8C8, 24'hC8C8C8, 24'hC8C8C8,
           1'b0, 1'b1, 24'h252525, 24'h252525);
      lat = 0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (m_valid_a) lat = i;
      end
      chk("latency", lat, 4);
      @(posedge clk);
      #1;

      send(6'd32, 6'd32, 24'h000000, 24'h646464, 24'hC8C8C8, 24'hFFFFFF,
           1'b0, 1'b0, 24'h8B8B8B, 24'h8A8A8A);
      send(6'd63, 6'd0, 24'h000000, 24'hFFFFFF, 24'h123456, 24'h654321,
           1'b0, 1'b1, 24'hFBFBFB, 24'hFBFBFB);
      send(6'd17, 6'd45, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
           1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF);
      send(6'd63, 6'd63, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
           1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
      send(6'd0, 6'd0, 24'h1E140A, 24'hABCDEF, 24'h778899, 24'h010203,
           1'b0, 1'b0, 24'h1E140A, 24'h1E140A);
      send(6'd20, 6'd9, 24'h1E140A, 24'hABCDEF, 24'h778899, 24'h010203,
           1'b1, 1'b1, 24'h101010, 24'h101010);
      send(6'd0, 6'd0, 24'h1E140A, 24'hABCDEF, 24'h778899, 24'h010203,
           1'b0, 1'b0, 24'h1E140A, 24'h1E140A);
      drain();

      // capacity: stalled output takes exactly four beats
      m_ready = 1'b0;
      base = n_acc;
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) rsend(1'b0);
            drv_done = 1'b1;
         end
      join_none
      repeat (10) @(posedge clk);
      #1;
      chk("cap_accepts", n_acc - base, 4);
      chk("cap_s_ready", s_ready_a, 0);
      chk("cap_busy", busy_a, 1);
      m_ready = 1'b1;
      for (int i = 0; i < 200 && !drv_done; i++) begin
         @(posedge clk);
         #1;
      end
      chk("cap_driver_done", drv_done, 1);
      drain();
      chk("cap_total", n_acc - base, 8);

      // random handshake traffic
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
         end
         rsend(1'b1);
      end
      drain();
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      chk("rand_no_loss", n_out, n_acc);

      // reset with three beats in flight
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) rsend(1'b0);
      chk("flight_busy", busy_a, 1);
      q.delete();
      outs = n_out;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_m_valid", m_valid_a, 0);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_s_ready", s_ready_a, 1);
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_no_stale", n_out, outs);
      rsend(1'b0);
      rsend(1'b1);
      drain();
      chk("midrst_resume", n_out, outs + 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
